bcd2bin_seq: RTL and testbench

Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per cycle, then apply -3 correction to each BCD digit.
Converts the packed-BCD score and level values coming from the game/keypad path back into binary for the compare and random-target logic.
Uses a start/done handshake and completes one conversion every BIN_W cycles.

---
 rtl/bcd_pkg.sv | 9 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bcd2bin_seq.sv | 94 +++++++++
 tb/tb_bcd2bin_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state type for the BCD-to-binary converter.
package bcd_pkg;
   localparam int BCD_DIGIT_W    = 4;
   localparam int BCD_MAX_DIGIT  = 9;
   localparam int BCD_ADJ_THRESH = 8;
   localparam int BCD_ADJ_OFFSET = 3;

   typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit reverse double-dabble correction: subtract 3 from a BCD field holding 8 or more.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);
   assign dout = (din >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? din - BCD_DIGIT_W'(BCD_ADJ_OFFSET) : din;
endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per cycle).
// Accepts start only when idle; result, err and ovf hold until the next completed request.
module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
   output logic                          busy,
   output logic                          done,
   output logic [BIN_W-1:0]              bin_out,
   output logic                          err,
   output logic                          ovf
);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int S_W   = BCD_W + BIN_W;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

   state_t           state;
   logic [S_W-1:0]   sreg;
   logic [S_W-1:0]   shifted;
   logic [S_W-1:0]   adj;
   logic [CNT_W-1:0] cnt;
   logic             bad_digit;

   assign shifted = sreg >> 1;
   assign adj[BIN_W-1:0] = shifted[BIN_W-1:0];

   // Only the BCD fields above the binary accumulator are corrected.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .dout (adj[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) bad_digit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         ovf     <= 1'b0;
         bin_out <= '0;
         cnt     <= '0;
         sreg    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (bad_digit) begin
                     // Rejected request still reports through the normal done pulse.
                     done    <= 1'b1;
                     err     <= 1'b1;
                     ovf     <= 1'b0;
                     bin_out <= '0;
                  end else begin
                     sreg  <= {bcd_in, {BIN_W{1'b0}}};
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               sreg <= adj;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  bin_out <= adj[BIN_W-1:0];
                  ovf     <= |adj[S_W-1:BIN_W];
                  err     <= 1'b0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: BIN_W=10 and BIN_W=6 instances against a cycle-level arithmetic model.
module tb_bcd2bin_seq;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       start_v = '0;
   logic [1:0][11:0] bcd_v   = '0;
   logic [1:0]       busy_v, done_v, err_v, ovf_v;
   logic [9:0]       bin_a;
   logic [5:0]       bin_b;

   bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) u_a (
      .clk(clk), .reset(reset), .start(start_v[0]), .bcd_in(bcd_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .bin_out(bin_a), .err(err_v[0]), .ovf(ovf_v[0]));

   bcd2bin_seq #(.DIGITS(3), .BIN_W(6)) u_b (
      .clk(clk), .reset(reset), .start(start_v[1]), .bcd_in(bcd_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .bin_out(bin_b), .err(err_v[1]), .ovf(ovf_v[1]));

   int n_chk = 0;
   int n_pass = 0;
   int ndone[2] = '{0, 0};

   function automatic int wid(input int d);
      return (d == 0) ? 10 : 6;
   endfunction

   function automatic logic [9:0] bin_of(input int d);
      return (d == 0) ? bin_a : {4'b0, bin_b};
   endfunction

   function automatic bit is_bad(input logic [11:0] v);
      return (v[3:0] > 9) || (v[7:4] > 9) || (v[11:8] > 9);
   endfunction

   function automatic int dec_of(input logic [11:0] v);
      return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [11:0] rand_bcd();
      logic [11:0] v;
      for (int i = 0; i < 3; i++) begin
         if ($urandom_range(0, 11) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
         else                            v[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[dut%0d] at %0t: got %0h, expected %0h", nm, d, $time, act, exp);
   endtask

   // Arithmetic reference: decimal value of the digits, reported modulo 2^BIN_W after BIN_W cycles.
   logic m_busy[2] = '{0, 0};
   logic m_done[2] = '{0, 0};
   logic m_err[2]  = '{0, 0};
   logic m_ovf[2]  = '{0, 0};
   logic [9:0] m_bin[2] = '{0, 0};
   int m_left[2] = '{0, 0};
   int m_val[2]  = '{0, 0};

   always @(posedge clk or negedge reset) begin
      for (int d = 0; d < 2; d++) begin
         if (!reset) begin
            m_busy[d] = 0; m_done[d] = 0; m_err[d] = 0; m_ovf[d] = 0; m_bin[d] = 0; m_left[d] = 0;
         end else begin
            m_done[d] = 0;
            if (m_busy[d]) begin
               m_left[d]--;
               if (m_left[d] == 0) begin
                  m_busy[d] = 0;
                  m_done[d] = 1;
                  m_err[d]  = 0;
                  m_ovf[d]  = (m_val[d] >= (1 << wid(d)));
                  m_bin[d]  = 10'(m_val[d] % (1 << wid(d)));
               end
            end else if (start_v[d]) begin
               if (is_bad(bcd_v[d])) begin
                  m_done[d] = 1; m_err[d] = 1; m_ovf[d] = 0; m_bin[d] = 0;
               end else begin
                  m_busy[d] = 1;
                  m_left[d] = wid(d);
                  m_val[d]  = dec_of(bcd_v[d]);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            chk("busy", d, 32'(busy_v[d]), 32'(m_busy[d]));
            chk("done", d, 32'(done_v[d]), 32'(m_done[d]));
            chk("err",  d, 32'(err_v[d]),  32'(m_err[d]));
            chk("ovf",  d, 32'(ovf_v[d]),  32'(m_ovf[d]));
            chk("bin",  d, 32'(bin_of(d)), 32'(m_bin[d]));
            if (done_v[d]) ndone[d]++;
         end
      end
   end

   task automatic pulse(input int d, input logic [11:0] v);
      @(negedge clk);
      start_v[d] = 1'b1;
      bcd_v[d]   = v;
      @(negedge clk);
      start_v[d] = 1'b0;
      bcd_v[d]   = 12'($urandom);
   endtask

   // Returns the number of edges after the accepting edge at which done appeared.
   task automatic wait_done(input int d, output int cyc);
      cyc = 0;
      while (!done_v[d] && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (!done_v[d]) chk("done_timeout", d, 32'(done_v[d]), 32'd1);
   endtask

   task automatic conv(input int d, input logic [11:0] v, input int lat,
                       input logic [9:0] bin, input logic e, input logic o);
      int cyc;
      pulse(d, v);
      chk("busy_after_accept", d, 32'(busy_v[d]), 32'(lat != 0));
      wait_done(d, cyc);
      chk("latency", d, 32'(cyc), 32'(lat));
      chk("lit_bin", d, 32'(bin_of(d)), 32'(bin));
      chk("lit_err", d, 32'(err_v[d]), 32'(e));
      chk("lit_ovf", d, 32'(ovf_v[d]), 32'(o));
   endtask

   initial begin
      int cyc;
      int n0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
      chk("rst_done", 0, 32'(done_v[0]), 32'd0);
      chk("rst_bin",  0, 32'(bin_a),     32'd0);
      chk("rst_err",  1, 32'(err_v[1]),  32'd0);
      chk("rst_ovf",  1, 32'(ovf_v[1]),  32'd0);
      reset = 1'b1;

      conv(0, 12'h999, 10, 10'h3E7, 1'b0, 1'b0);
      conv(0, 12'h063, 10, 10'd63,  1'b0, 1'b0);
      conv(0, 12'h000, 10, 10'd0,   1'b0, 1'b0);
      conv(0, 12'h0A5, 0,  10'd0,   1'b1, 1'b0);
      conv(1, 12'h100, 6,  10'd36,  1'b0, 1'b1);
      conv(1, 12'h063, 6,  10'd63,  1'b0, 1'b0);
      conv(1, 12'h999, 6,  10'd39,  1'b0, 1'b1);

      // A start during a conversion is dropped; a start in the done cycle is taken.
      @(negedge clk);
      n0 = ndone[0];
      pulse(0, 12'h123);
      repeat (3) @(negedge clk);
      pulse(0, 12'h456);
      wait_done(0, cyc);
      chk("ignored_start_bin", 0, 32'(bin_a), 32'd123);
      start_v[0] = 1'b1;
      bcd_v[0]   = 12'h456;
      @(negedge clk);
      start_v[0] = 1'b0;
      bcd_v[0]   = 12'h987;
      wait_done(0, cyc);
      chk("b2b_latency", 0, 32'(cyc), 32'd10);
      chk("b2b_bin", 0, 32'(bin_a), 32'd456);
      repeat (12) @(negedge clk);
      chk("done_count", 0, 32'(ndone[0] - n0), 32'd2);

      // Reset in the middle of a conversion.
      n0 = ndone[0];
      pulse(0, 12'h999);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_busy", 0, 32'(busy_v[0]), 32'd0);
      chk("midrst_bin",  0, 32'(bin_a),     32'd0);
      repeat (3) @(negedge clk);
      chk("midrst_done", 0, 32'(done_v[0]), 32'd0);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      chk("midrst_no_done", 0, 32'(ndone[0] - n0), 32'd0);
      conv(0, 12'h042, 10, 10'd42, 1'b0, 1'b0);

      // Random traffic on both instances, including starts while busy and invalid digits.
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            start_v[d] = ($urandom_range(0, 2) == 0);
            bcd_v[d]   = rand_bcd();
         end
      end
      @(negedge clk);
      start_v = '0;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
